// File: rtl/seq_det_pkg.sv
// seq_det_pkg -- shared types and constants for the serial pattern detector.
//   state_e   : controller FSM state encoding
//   WD_LIMIT  : watchdog terminal count (valid bits without a hit)
package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_CONFIGURED = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } state_e;

  localparam logic [15:0] WD_LIMIT = 16'hFFFF;

endpackage

// File: rtl/seq_det_shifter.sv
// seq_det_shifter -- history shift register, fill counter and pattern compare.
// Ports:
//   clk, reset    : clock, asynchronous active-low reset
//   clear_i       : synchronous clear of history and fill count
//   shift_en_i    : shift xin_i into the history this cycle
//   xin_i         : serial data bit
//   overlap_i     : 1 = keep history/fill after a match, 0 = restart fill
//   pattern_i     : pattern to detect, MSB is the oldest bit
//   match_o       : combinational; the bit being shifted completes a match
module seq_det_shifter #(
  parameter int unsigned PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             shift_en_i,
  input  logic             xin_i,
  input  logic             overlap_i,
  input  logic [PAT_W-1:0] pattern_i,
  output logic             match_o
);

  localparam int unsigned       FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_inc;

  // Match is evaluated on the post-shift view so the registered hit can
  // appear the cycle right after the completing sample.
  always_comb begin
    hist_d   = {hist_q[PAT_W-2:0], xin_i};
    fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    match_o  = shift_en_i && (fill_inc == FILL_FULL) && (hist_d == pattern_i);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (clear_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (shift_en_i) begin
      hist_q <= hist_d;
      fill_q <= (match_o && !overlap_i) ? '0 : fill_inc;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl -- configurable serial pattern detector with match counter.
// Optional watchdog: define SEQ_DETECT_CTRL_TIMEOUT_EN to build it; otherwise
// timeout is tied low.
// Ports:
//   clk, reset                : clock, asynchronous active-low reset
//   cfg_valid/cfg_pattern/cfg_overlap/cfg_target : configuration write
//   start, abort              : arm detection / return to IDLE (abort wins)
//   xin, xin_valid            : qualified serial data
//   cfg_ready, busy           : IDLE|CONFIGURED, RUN
//   hit, done                 : registered one-cycle pulses
//   match_cnt                 : matches since start
//   timeout                   : watchdog flag
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic             cfg_overlap,
  input  logic [CNT_W-1:0] cfg_target,
  input  logic             start,
  input  logic             abort,
  input  logic             xin,
  input  logic             xin_valid,
  output logic             cfg_ready,
  output logic             busy,
  output logic             hit,
  output logic [CNT_W-1:0] match_cnt,
  output logic             done,
  output logic             timeout
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pattern_q;
  logic             overlap_q;
  logic [CNT_W-1:0] target_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             hit_q, done_q;
  logic             cfg_load, run_start, shift_en, match, reach;

  // abort gates everything so a completing bit in the abort cycle is lost.
  assign run_start = !abort && start &&
                     ((state_q == ST_CONFIGURED) || (state_q == ST_DONE));
  assign shift_en  = !abort && (state_q == ST_RUN) && xin_valid;

  seq_det_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (run_start),
    .shift_en_i(shift_en),
    .xin_i     (xin),
    .overlap_i (overlap_q),
    .pattern_i (pattern_q),
    .match_o   (match)
  );

  always_comb begin
    cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    reach    = match && (target_q != '0) && (cnt_inc == target_q);
    cnt_d    = run_start ? '0 : (match ? cnt_inc : cnt_q);
    state_d  = state_q;
    cfg_load = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cfg_valid) begin
            cfg_load = 1'b1;
            state_d  = ST_CONFIGURED;
          end
        end
        ST_CONFIGURED: begin
          cfg_load = cfg_valid;
          if (start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (reach) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
          end else if (cfg_valid) begin
            cfg_load = 1'b1;
            state_d  = ST_CONFIGURED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pattern_q <= '0;
      overlap_q <= 1'b0;
      target_q  <= '0;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= match;
      done_q  <= reach;
      if (cfg_load) begin
        pattern_q <= cfg_pattern;
        overlap_q <= cfg_overlap;
        target_q  <= cfg_target;
      end
    end
  end

  assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_CONFIGURED);
  assign busy      = (state_q == ST_RUN);
  assign hit       = hit_q;
  assign done      = done_q;
  assign match_cnt = cnt_q;

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        timeout_q, timeout_d;

  // Counts valid bits seen in RUN/DONE since the last hit or start; the flag
  // is sticky until start/abort.
  always_comb begin
    wd_d      = wd_q;
    timeout_d = timeout_q;
    if (abort || run_start) begin
      wd_d      = '0;
      timeout_d = 1'b0;
    end else if (match) begin
      wd_d = '0;
    end else if (xin_valid && ((state_q == ST_RUN) || (state_q == ST_DONE)) &&
                 (wd_q != WD_LIMIT)) begin
      wd_d = wd_q + 16'd1;
      if (wd_d == WD_LIMIT) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl -- directed, table-driven bench for seq_detect_ctrl.
// Watchdog checks are built when SEQ_DETECT_CTRL_TIMEOUT_EN is defined.
module tb_seq_detect_ctrl;

  localparam int unsigned PAT_W = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk, reset;
  logic             cfg_valid, cfg_overlap, start, abort, xin, xin_valid;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_target;
  logic             cfg_ready, busy, hit, done, timeout;
  logic [CNT_W-1:0] match_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  seq_detect_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_pattern(cfg_pattern),
    .cfg_overlap(cfg_overlap),
    .cfg_target (cfg_target),
    .start      (start),
    .abort      (abort),
    .xin        (xin),
    .xin_valid  (xin_valid),
    .cfg_ready  (cfg_ready),
    .busy       (busy),
    .hit        (hit),
    .match_cnt  (match_cnt),
    .done       (done),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       cv;
    logic [3:0] pat;
    logic       ov;
    logic [7:0] tgt;
    logic       st, ab, x, xv;
    logic       e_hit, e_done;
    logic [7:0] e_cnt;
    logic       e_busy, e_ready;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic cv, logic [3:0] pat, logic ov, logic [7:0] tgt,
                              logic st, logic ab, logic x, logic xv,
                              logic eh, logic ed, logic [7:0] ec, logic eb, logic er);
    vec_t v;
    v.cv = cv; v.pat = pat; v.ov = ov; v.tgt = tgt;
    v.st = st; v.ab = ab; v.x = x; v.xv = xv;
    v.e_hit = eh; v.e_done = ed; v.e_cnt = ec; v.e_busy = eb; v.e_ready = er;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; cfg_pattern = '0; cfg_overlap = 0; cfg_target = '0;
    start = 0; abort = 0; xin = 0; xin_valid = 0;
  endtask

  task automatic bits4(input logic [3:0] b);
    for (int k = 3; k >= 0; k--) begin
      xin = b[k]; xin_valid = 1; tick();
    end
    xin_valid = 0;
  endtask

  task automatic check_outs(input string tag, input logic eh, input logic ed,
                            input logic [7:0] ec, input logic eb, input logic er);
    check({tag, ".hit"},   32'(hit),       32'(eh));
    check({tag, ".done"},  32'(done),      32'(ed));
    check({tag, ".cnt"},   32'(match_cnt), 32'(ec));
    check({tag, ".busy"},  32'(busy),      32'(eb));
    check({tag, ".ready"}, 32'(cfg_ready), 32'(er));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 0;
    tick();
    tick();
    check_outs("rst", 0, 0, 8'd0, 0, 1);
    check("rst.timeout", 32'(timeout), 32'd0);
    reset = 1;
    tick();

    // overlap=1, target=2, stream 1011011
    vecs.push_back(mk(1, 4'hB, 1, 8'd2, 0, 0, 0, 0,  0, 0, 8'd0, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0, 0, 0,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  1, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 1,  0, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  1, 1, 8'd2, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 0,  0, 0, 8'd2, 0, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd2, 0, 0));
    // re-run from DONE with the same configuration
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0, 0, 0,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  1, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 1, 0, 0,  0, 0, 8'd1, 0, 1));
    // overlap=0, same stream: single hit, stays in RUN
    vecs.push_back(mk(1, 4'hB, 0, 8'd2, 0, 0, 0, 0,  0, 0, 8'd1, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0, 0, 0,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  1, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 1,  0, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 1,  0, 0, 8'd1, 1, 0));
    // cfg_valid ignored in RUN
    vecs.push_back(mk(1, 4'h0, 1, 8'd0, 0, 0, 0, 0,  0, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 1, 0, 0,  0, 0, 8'd1, 0, 1));
    // alternate invalid cycles carry junk that would break the match
    vecs.push_back(mk(1, 4'hB, 1, 8'd0, 0, 0, 0, 0,  0, 0, 8'd1, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0, 0, 0,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 0,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 0,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 0,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  1, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 0,  0, 0, 8'd1, 1, 0));
    // abort on the completing bit: no hit, IDLE, count kept
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 1,  0, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd1, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 1, 1, 1,  0, 0, 8'd1, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 0,  0, 0, 8'd1, 0, 1));
    // start+abort together: abort wins; start ignored in IDLE
    vecs.push_back(mk(1, 4'hB, 1, 8'd1, 0, 0, 0, 0,  0, 0, 8'd1, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 1, 0, 0,  0, 0, 8'd1, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0, 0, 0,  0, 0, 8'd1, 0, 1));
    // target=1 completes on the first hit, then re-configure from DONE
    vecs.push_back(mk(1, 4'hB, 1, 8'd1, 0, 0, 0, 0,  0, 0, 8'd1, 0, 1));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 1, 0, 0, 0,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 0, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  0, 0, 8'd0, 1, 0));
    vecs.push_back(mk(0, 4'h0, 0, 8'd0, 0, 0, 1, 1,  1, 1, 8'd1, 0, 0));
    vecs.push_back(mk(1, 4'h5, 0, 8'd3, 0, 0, 0, 0,  0, 0, 8'd1, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      cfg_valid = vecs[i].cv; cfg_pattern = vecs[i].pat;
      cfg_overlap = vecs[i].ov; cfg_target = vecs[i].tgt;
      start = vecs[i].st; abort = vecs[i].ab;
      xin = vecs[i].x; xin_valid = vecs[i].xv;
      tick();
      check_outs($sformatf("v%0d", i), vecs[i].e_hit, vecs[i].e_done,
                 vecs[i].e_cnt, vecs[i].e_busy, vecs[i].e_ready);
      check($sformatf("v%0d.timeout", i), 32'(timeout), 32'd0);
    end
    idle_inputs();

    // reset asserted mid-match
    abort = 1; tick(); abort = 0;
    cfg_valid = 1; cfg_pattern = 4'hB; cfg_overlap = 1; cfg_target = 8'd0; tick();
    idle_inputs();
    start = 1; tick(); start = 0;
    bits4(4'hB);
    check_outs("rm.pre", 1, 0, 8'd1, 1, 0);
    xin = 0; xin_valid = 1; tick();
    xin = 1; tick();
    xin = 1; xin_valid = 1;
    #2 reset = 0;
    #1 check_outs("rm.async", 0, 0, 8'd0, 0, 1);
    check("rm.async.timeout", 32'(timeout), 32'd0);
    tick();
    reset = 1;
    tick();
    check_outs("rm.post", 0, 0, 8'd0, 0, 1);
    xin_valid = 0;
    cfg_valid = 1; cfg_pattern = 4'hB; cfg_overlap = 1; cfg_target = 8'd0; tick();
    idle_inputs();
    start = 1; tick(); start = 0;
    bits4(4'hB);
    check_outs("rm.fresh", 1, 0, 8'd1, 1, 0);

`ifdef SEQ_DETECT_CTRL_TIMEOUT_EN
    abort = 1; tick(); abort = 0;
    cfg_valid = 1; cfg_pattern = 4'hB; cfg_overlap = 1; cfg_target = 8'd1; tick();
    idle_inputs();
    start = 1; tick(); start = 0;
    bits4(4'hB);
    check_outs("wd.done", 1, 1, 8'd1, 0, 0);
    xin = 0; xin_valid = 1;
    for (int k = 0; k < 65534; k++) tick();
    check("wd.before", 32'(timeout), 32'd0);
    tick();
    check("wd.set", 32'(timeout), 32'd1);
    xin_valid = 0; tick();
    check("wd.sticky", 32'(timeout), 32'd1);
    start = 1; tick(); start = 0;
    check("wd.cleared", 32'(timeout), 32'd0);
    check("wd.busy", 32'(busy), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
